alu: RTL and testbench

//  Registered WIDTH-bit arithmetic/logic unit. Operands a, b and opcode sel are

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 63 ++++++
 rtl/alu.sv | 57 +++++
 tb/tb_alu.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and status flag bundle for the registered ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: decodes sel, produces result and status flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] y,
  output alu_flags_t       flags
);

  localparam int MSB = WIDTH - 1;

  // Extra top bit carries the unsigned carry-out (ADD) or borrow (SUB).
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; every path assigns every output so no latch can form.
  always_comb begin
    y              = '0;
    flags.carry    = 1'b0;
    flags.overflow = 1'b0;
    case (sel)
      OP_ADD: begin
        y              = sum[MSB:0];
        flags.carry    = sum[WIDTH];
        // Same-signed operands producing a differently-signed result.
        flags.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        y              = diff[MSB:0];
        flags.carry    = diff[WIDTH];
        // Opposite-signed operands where the result sign departs from a.
        flags.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y           = {a[MSB-1:0], 1'b0};
        flags.carry = a[MSB];
      end
      OP_SHR: begin
        y           = {1'b0, a[MSB:1]};
        flags.carry = a[0];
      end
      default: begin
        y              = '0;
        flags.carry    = 1'b0;
        flags.overflow = 1'b0;
      end
    endcase
    flags.zero     = (y == '0);
    flags.negative = y[MSB];
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, results and flags held while idle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] y_c;
  alu_flags_t       flags_c;
  alu_flags_t       flags_q;
  logic [WIDTH-1:0] y_q;
  logic             vld_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (a),
    .b     (b),
    .sel   (sel),
    .y     (y_c),
    .flags (flags_c)
  );

  // Capture result/flags only on accepted inputs; out_valid pulses per accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      flags_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        y_q     <= y_c;
        flags_q <= flags_c;
      end
    end
  end

  assign y         = y_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign overflow  = flags_q.overflow;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed steps plus randomized traffic against
// an integer-arithmetic reference model.
module tb_alu;
  localparam int W = 4;
  localparam int M = 1 << W;
  localparam int H = M / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b, y;
  logic [2:0]   sel;
  logic         in_valid, carry, zero, negative, overflow, out_valid;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] ey;
  logic         ec, ez, en, eo, ev;

  always #5 clk = ~clk;

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .in_valid  (in_valid),
    .y         (y),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  function automatic int sgn(input int v);
    return (v >= H) ? v - M : v;
  endfunction

  task automatic model_reset();
    ey = '0; ec = 0; ez = 0; en = 0; eo = 0; ev = 0;
  endtask

  // Reference: plain integer arithmetic over the value ranges.
  task automatic model_step(input int av, input int bv, input int sv, input bit iv);
    int r, s, c, o;
    ev = iv;
    if (!iv) return;
    r = 0; c = 0; o = 0;
    case (sv)
      0: begin r = av + bv; c = int'(r >= M); s = sgn(av) + sgn(bv); o = int'(s >= H || s < -H); end
      1: begin r = av - bv; c = int'(av < bv); s = sgn(av) - sgn(bv); o = int'(s >= H || s < -H); end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = M - 1 - av;
      6: begin r = av * 2; c = int'(av >= H); end
      default: begin r = av / 2; c = av % 2; end
    endcase
    r  = ((r % M) + M) % M;
    ey = W'(r);
    ec = (c != 0);
    eo = (o != 0);
    ez = (r == 0);
    en = (r >= H);
  endtask

  task automatic check(input string tag);
    checks++;
    assert ({y, carry, zero, negative, overflow, out_valid} === {ey, ec, ez, en, eo, ev})
    else begin
      errors++;
      $error("FAIL %s got y=%h c=%b z=%b n=%b o=%b v=%b exp y=%h c=%b z=%b n=%b o=%b v=%b",
             tag, y, carry, zero, negative, overflow, out_valid, ey, ec, ez, en, eo, ev);
    end
  endtask

  task automatic check_lit(input string tag, input logic [W+4:0] got, input logic [W+4:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive on falling edge, model the rising edge, sample 1 time unit later.
  task automatic cycle(input int av, input int bv, input int sv, input bit iv, input string tag);
    @(negedge clk);
    a = W'(av); b = W'(bv); sel = 3'(sv); in_valid = iv;
    @(posedge clk);
    model_step(av, bv, sv, iv);
    #1;
    check(tag);
  endtask

  initial begin
    int ys[5];
    ys = '{8, 2, 1, 7, 6};

    rst_n = 1'b0; a = 4'h5; b = 4'h3; sel = 3'd0; in_valid = 1'b1;
    model_reset();
    #22;
    check("reset");

    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    cycle(5, 3, 0, 0, "idle0");
    cycle(9, 9, 1, 0, "idle1");

    // a=0101, b=0011 through ADD..XOR.
    for (int i = 0; i < 5; i++) begin
      cycle(5, 3, i, 1, $sformatf("op%0d", i));
      check_lit($sformatf("op%0d_lit", i), {4'b0, y, out_valid}, {4'b0, W'(ys[i]), 1'b1});
    end

    cycle(15, 1, 0, 1, "add_wrap");
    check_lit("add_wrap_lit", {y, carry, zero, negative, overflow, 1'b0}, {4'h0, 5'b11000});
    cycle(3, 5, 1, 1, "sub_borrow");
    check_lit("sub_borrow_lit", {y, carry, zero, negative, overflow, 1'b0}, {4'he, 5'b10100});
    cycle(8, 1, 1, 1, "sub_ovf");
    cycle(9, 0, 5, 1, "not");
    check_lit("not_lit", {4'b0, y, 1'b0}, {4'b0, 4'h6, 1'b0});
    cycle(9, 0, 6, 1, "shl");
    check_lit("shl_lit", {4'b0, y, carry}, {4'b0, 4'h2, 1'b1});
    cycle(9, 0, 7, 1, "shr");
    check_lit("shr_lit", {4'b0, y, carry}, {4'b0, 4'h4, 1'b1});

    // Valid toggling: result holds through the gap.
    cycle(6, 7, 0, 1, "tog1");
    cycle(1, 1, 2, 0, "tog0");
    cycle(2, 2, 4, 1, "tog2");

    // Reset between edges with a live input.
    cycle(7, 2, 0, 1, "pre_rst");
    @(negedge clk);
    a = 4'h3; b = 4'h4; sel = 3'd0; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst");
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    cycle(0, 0, 0, 0, "post_rst");

    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, M - 1), $urandom_range(0, M - 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $sformatf("rnd%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
